// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

   // Controller states, in the order a normal calculation walks through them
   typedef enum logic [2:0] {
      ST_OP1    = 3'd0,
      ST_OP2    = 3'd1,
      ST_EXEC   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_RESULT = 3'd4,
      ST_ERROR  = 3'd5
   } state_t;

   // Keypad event classes as delivered by the push-button decoder
   typedef enum logic [1:0] {
      KEY_DIG = 2'd0,
      KEY_OP  = 2'd1,
      KEY_ENT = 2'd2,
      KEY_CLR = 2'd3
   } key_type_t;

   // ALU operations understood by the datapath
   typedef enum logic [2:0] {
      ADD = 3'd0,
      SUB = 3'd1,
      MUL = 3'd2,
      AND = 3'd3,
      OR  = 3'd4,
      XOR = 3'd5
   } opcode_t;

   localparam logic [2:0] OPCODE_MAX  = 3'd5;
   localparam logic [7:0] OPERAND_MAX = 8'd255;
   localparam logic [3:0] DIGIT_MAX   = 4'd9;

   // True when the low three key bits name an operation the ALU implements
   function automatic logic isValidOpcode(input logic [2:0] code);
      return code <= OPCODE_MAX;
   endfunction

   // True when a digit key carries a decimal digit rather than a stray code
   function automatic logic isValidDigit(input logic [3:0] digit);
      return digit <= DIGIT_MAX;
   endfunction

endpackage

// File: rtl/calc_digit_acc.sv
// Decimal digit accumulator: appends one digit to an 8-bit operand.
// Purely combinational; the controller decides whether to keep the sum.
module calc_digit_acc
   import calc_pkg::*;
(
   input  logic [7:0] acc,
   input  logic [3:0] digit,
   output logic [7:0] sum,
   output logic       ovf
);

   // 255*10 + 9 = 2559 needs 12 bits, so the intermediate never wraps
   logic [11:0] wideSum;

   // Shift the operand one decimal place left and add the new digit
   always_comb begin
      wideSum = ({4'b0000, acc} * 12'd10) + {8'h00, digit};
      ovf     = wideSum > {4'b0000, OPERAND_MAX};
      sum     = wideSum[7:0];
   end

endmodule

// File: rtl/calc_ctrl.sv
// Sequencing controller for the calculator datapath.
// Builds two decimal operands from keypad strobes, launches the ALU with a
// single-cycle enable, supervises the ALU handshake with a timeout and holds
// the result for the display drivers. Every output comes straight from a flop.
module calc_ctrl
   import calc_pkg::*;
#(
   parameter int ALU_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       key_valid,
   input  logic [1:0] key_type,
   input  logic [3:0] key_val,
   input  logic       alu_done,
   input  logic       alu_ovf,
   input  logic [8:0] alu_result,
   output logic [7:0] op1,
   output logic [7:0] op2,
   output logic [2:0] opcode,
   output logic       alu_en,
   output logic [8:0] disp_val,
   output logic       err,
   output logic       busy
);

   // Wide enough to hold ALU_TIMEOUT itself; at least one bit
   localparam int CNT_W = (ALU_TIMEOUT > 1) ? $clog2(ALU_TIMEOUT + 1) : 1;

   state_t           state_q, state_d;
   logic [7:0]       op1_q, op1_d;
   logic [7:0]       op2_q, op2_d;
   opcode_t          opcode_q, opcode_d;
   logic [8:0]       result_q, result_d;
   logic             op2Seen_q, op2Seen_d;
   logic [CNT_W-1:0] timeoutCnt_q, timeoutCnt_d;

   logic             aluEn_q;
   logic [8:0]       dispVal_q, dispVal_d;
   logic             err_q;
   logic             busy_q;

   key_type_t        keyType;
   logic             keyDigit;
   logic             keyOp;
   logic             keyEnter;
   logic             keyClear;

   logic [7:0]       accIn;
   logic [7:0]       accSum;
   logic             accOvf;

   assign keyType = key_type_t'(key_type);

   // Qualify raw key strobes; malformed digits and opcodes never reach the FSM
   always_comb begin
      keyDigit = key_valid && (keyType == KEY_DIG) && isValidDigit(key_val);
      keyOp    = key_valid && (keyType == KEY_OP)  && isValidOpcode(key_val[2:0]);
      keyEnter = key_valid && (keyType == KEY_ENT);
      keyClear = key_valid && (keyType == KEY_CLR);
   end

   // One shared accumulator: second operand while in OP2, first operand otherwise
   always_comb begin
      accIn = (state_q == ST_OP2) ? op2_q : op1_q;
   end

   calc_digit_acc uDigitAcc (
      .acc   (accIn),
      .digit (key_val),
      .sum   (accSum),
      .ovf   (accOvf)
   );

   // Next-state and next-register computation; clear overrides everything
   always_comb begin
      state_d      = state_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      opcode_d     = opcode_q;
      result_d     = result_q;
      op2Seen_d    = op2Seen_q;
      timeoutCnt_d = timeoutCnt_q;

      if (keyClear) begin
         state_d      = ST_OP1;
         op1_d        = 8'd0;
         op2_d        = 8'd0;
         opcode_d     = ADD;
         result_d     = 9'd0;
         op2Seen_d    = 1'b0;
         timeoutCnt_d = '0;
      end else begin
         unique case (state_q)
            ST_OP1: begin
               if (keyDigit) begin
                  if (accOvf) begin
                     state_d = ST_ERROR;
                  end else begin
                     op1_d = accSum;
                  end
               end else if (keyOp) begin
                  opcode_d  = opcode_t'(key_val[2:0]);
                  op2_d     = 8'd0;
                  op2Seen_d = 1'b0;
                  state_d   = ST_OP2;
               end
            end

            ST_OP2: begin
               if (keyDigit) begin
                  if (accOvf) begin
                     state_d = ST_ERROR;
                  end else begin
                     op2_d     = accSum;
                     op2Seen_d = 1'b1;
                  end
               end else if (keyOp) begin
                  if (!op2Seen_q) begin
                     opcode_d = opcode_t'(key_val[2:0]);
                  end
               end else if (keyEnter) begin
                  if (op2Seen_q) begin
                     state_d = ST_EXEC;
                  end
               end
            end

            ST_EXEC: begin
               timeoutCnt_d = CNT_W'(ALU_TIMEOUT);
               state_d      = ST_WAIT;
            end

            ST_WAIT: begin
               if (alu_done) begin
                  if (alu_ovf) begin
                     state_d = ST_ERROR;
                  end else begin
                     result_d = alu_result;
                     state_d  = ST_RESULT;
                  end
               end else if (timeoutCnt_q <= CNT_W'(1)) begin
                  timeoutCnt_d = '0;
                  state_d      = ST_ERROR;
               end else begin
                  timeoutCnt_d = timeoutCnt_q - CNT_W'(1);
               end
            end

            ST_RESULT: begin
               if (keyDigit) begin
                  op1_d   = {4'h0, key_val};
                  state_d = ST_OP1;
               end else if (keyOp) begin
                  if (result_q[8]) begin
                     state_d = ST_ERROR;
                  end else begin
                     // Chain the result as the new first operand; the second
                     // operand starts fresh exactly as it does from OP1
                     op1_d     = result_q[7:0];
                     opcode_d  = opcode_t'(key_val[2:0]);
                     op2_d     = 8'd0;
                     op2Seen_d = 1'b0;
                     state_d   = ST_OP2;
                  end
               end
            end

            ST_ERROR: begin
               state_d = ST_ERROR;
            end

            default: begin
               state_d = ST_OP1;
            end
         endcase
      end
   end

   // Display value follows the state being entered so it lands with the state
   always_comb begin
      dispVal_d = 9'd0;
      unique case (state_d)
         ST_OP1:                  dispVal_d = {1'b0, op1_d};
         ST_OP2, ST_EXEC, ST_WAIT: dispVal_d = {1'b0, op2_d};
         ST_RESULT:               dispVal_d = result_d;
         default:                 dispVal_d = 9'd0;
      endcase
   end

   // State, operand registers and registered outputs; reset drops everything at once
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= ST_OP1;
         op1_q        <= 8'd0;
         op2_q        <= 8'd0;
         opcode_q     <= ADD;
         result_q     <= 9'd0;
         op2Seen_q    <= 1'b0;
         timeoutCnt_q <= '0;
         aluEn_q      <= 1'b0;
         dispVal_q    <= 9'd0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         opcode_q     <= opcode_d;
         result_q     <= result_d;
         op2Seen_q    <= op2Seen_d;
         timeoutCnt_q <= timeoutCnt_d;
         aluEn_q      <= (state_d == ST_EXEC);
         dispVal_q    <= dispVal_d;
         err_q        <= (state_d == ST_ERROR);
         busy_q       <= (state_d == ST_EXEC) || (state_d == ST_WAIT);
      end
   end

   assign op1      = op1_q;
   assign op2      = op2_q;
   assign opcode   = opcode_q;
   assign alu_en   = aluEn_q;
   assign disp_val = dispVal_q;
   assign err      = err_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl: the driver pushes the expected output
// snapshot tagged with the cycle it must appear in; a monitor pops and
// compares on every falling edge.
module tb_calc_ctrl;

   localparam logic [1:0] KDIG = 2'd0;
   localparam logic [1:0] KOP  = 2'd1;
   localparam logic [1:0] KENT = 2'd2;
   localparam logic [1:0] KCLR = 2'd3;

   logic       clk = 1'b0;
   logic       nrst;
   logic       key_valid;
   logic [1:0] key_type;
   logic [3:0] key_val;
   logic       alu_done;
   logic       alu_ovf;
   logic [8:0] alu_result;
   logic [7:0] op1;
   logic [7:0] op2;
   logic [2:0] opcode;
   logic       alu_en;
   logic [8:0] disp_val;
   logic       err;
   logic       busy;

   typedef struct {
      string      name;
      int         stamp;
      logic [7:0] op1;
      logic [7:0] op2;
      logic [2:0] opc;
      logic       en;
      logic [8:0] disp;
      logic       err;
      logic       busy;
   } exp_t;

   exp_t expQ[$];
   int   cycleCnt    = 0;
   int   vectors     = 0;
   int   miscompares = 0;

   calc_ctrl #(.ALU_TIMEOUT(15)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .key_valid  (key_valid),
      .key_type   (key_type),
      .key_val    (key_val),
      .alu_done   (alu_done),
      .alu_ovf    (alu_ovf),
      .alu_result (alu_result),
      .op1        (op1),
      .op2        (op2),
      .opcode     (opcode),
      .alu_en     (alu_en),
      .disp_val   (disp_val),
      .err        (err),
      .busy       (busy)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Cycle index used to time-stamp expectations
   always @(posedge clk) cycleCnt++;

   // Compare one expected snapshot against the live outputs
   task automatic checkOutput(input exp_t e);
      vectors++;
      if (op1 !== e.op1 || op2 !== e.op2 || opcode !== e.opc || alu_en !== e.en ||
          disp_val !== e.disp || err !== e.err || busy !== e.busy) begin
         miscompares++;
         $display("[TB] FAIL %s @%0d: got op1=%0d op2=%0d opc=%0d en=%b disp=%0d err=%b busy=%b, want op1=%0d op2=%0d opc=%0d en=%b disp=%0d err=%b busy=%b",
                  e.name, cycleCnt, op1, op2, opcode, alu_en, disp_val, err, busy,
                  e.op1, e.op2, e.opc, e.en, e.disp, e.err, e.busy);
      end
   endtask

   // Monitor: every falling edge, retire all expectations due by now
   always @(negedge clk) begin
      exp_t e;
      while (expQ.size() > 0 && expQ[0].stamp <= cycleCnt) begin
         e = expQ.pop_front();
         checkOutput(e);
      end
   end

   // Queue an expectation for a specific cycle
   task automatic pushExp(input string nm, input int stamp, input int o1, input int o2,
                          input int opc, input bit en, input int disp, input bit er, input bit bz);
      exp_t e;
      e.name  = nm;
      e.stamp = stamp;
      e.op1   = 8'(o1);
      e.op2   = 8'(o2);
      e.opc   = 3'(opc);
      e.en    = en;
      e.disp  = 9'(disp);
      e.err   = er;
      e.busy  = bz;
      expQ.push_back(e);
   endtask

   // Expectation for the outputs after the coming rising edge
   task automatic expectNext(input string nm, input int o1, input int o2, input int opc,
                             input bit en, input int disp, input bit er, input bit bz);
      pushExp(nm, cycleCnt + 1, o1, o2, opc, en, disp, er, bz);
   endtask

   // Drive one cycle of inputs on the falling edge
   task automatic applyStimulus(input logic kv, input logic [1:0] kt, input logic [3:0] v,
                                input logic dn, input logic ov, input logic [8:0] res);
      @(negedge clk);
      key_valid  = kv;
      key_type   = kt;
      key_val    = v;
      alu_done   = dn;
      alu_ovf    = ov;
      alu_result = res;
   endtask

   task automatic key(input logic [1:0] kt, input logic [3:0] v);
      applyStimulus(1'b1, kt, v, 1'b0, 1'b0, 9'd0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, KDIG, 4'd0, 1'b0, 1'b0, 9'd0);
   endtask

   task automatic aluResp(input logic ov, input logic [8:0] res);
      applyStimulus(1'b0, KDIG, 4'd0, 1'b1, ov, res);
   endtask

   // Directed sequence with hand-computed expectations
   initial begin
      nrst = 1'b0;
      key_valid = 1'b0; key_type = KDIG; key_val = 4'd0;
      alu_done = 1'b0; alu_ovf = 1'b0; alu_result = 9'd0;

      @(negedge clk); expectNext("reset", 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk); nrst = 1'b1;

      // 12 op0 3 = 15 with the ALU answering two cycles after alu_en
      key(KDIG, 4'd1); expectNext("d1",       1, 0, 0, 0,  1, 0, 0);
      key(KDIG, 4'd2); expectNext("d2",      12, 0, 0, 0, 12, 0, 0);
      key(KOP,  4'd0); expectNext("op0",     12, 0, 0, 0,  0, 0, 0);
      key(KDIG, 4'd3); expectNext("d3",      12, 3, 0, 0,  3, 0, 0);
      key(KENT, 4'd0); expectNext("exec",    12, 3, 0, 1,  3, 0, 1);
      idle();          expectNext("wait1",   12, 3, 0, 0,  3, 0, 1);
      idle();          expectNext("wait2",   12, 3, 0, 0,  3, 0, 1);
      aluResp(1'b0, 9'd15); expectNext("res15", 12, 3, 0, 0, 15, 0, 0);
      idle();          expectNext("res_hold",12, 3, 0, 0, 15, 0, 0);

      // Chain from RESULT, then a result with bit 8 set refuses to chain
      key(KOP,  4'd2); expectNext("chain",   15, 0, 2, 0,  0, 0, 0);
      key(KDIG, 4'd4); expectNext("c_d4",    15, 4, 2, 0,  4, 0, 0);
      key(KENT, 4'd0); expectNext("c_exec",  15, 4, 2, 1,  4, 0, 1);
      idle();          expectNext("c_wait",  15, 4, 2, 0,  4, 0, 1);
      aluResp(1'b0, 9'h1FF); expectNext("res1ff", 15, 4, 2, 0, 511, 0, 0);
      key(KOP,  4'd1); expectNext("bit8err", 15, 4, 2, 0,  0, 1, 0);
      key(KDIG, 4'd5); expectNext("err_hold",15, 4, 2, 0,  0, 1, 0);
      key(KCLR, 4'd0); expectNext("clr1",     0, 0, 0, 0,  0, 0, 0);

      // Operand overflow: 25 then 6 would be 256
      key(KDIG, 4'd2); expectNext("o_d2",     2, 0, 0, 0,  2, 0, 0);
      key(KDIG, 4'd5); expectNext("o_d5",    25, 0, 0, 0, 25, 0, 0);
      key(KDIG, 4'd6); expectNext("o_ovf",   25, 0, 0, 0,  0, 1, 0);
      key(KCLR, 4'd0); expectNext("clr2",     0, 0, 0, 0,  0, 0, 0);

      // Ignored keys: bad digit, enter in OP1, opcode rules in OP2
      key(KDIG, 4'd10); expectNext("bad_dig", 0, 0, 0, 0,  0, 0, 0);
      key(KENT, 4'd0);  expectNext("ent_op1", 0, 0, 0, 0,  0, 0, 0);
      key(KDIG, 4'd7); expectNext("i_d7",     7, 0, 0, 0,  7, 0, 0);
      key(KOP,  4'd1); expectNext("i_op1",    7, 0, 1, 0,  0, 0, 0);
      key(KOP,  4'd4); expectNext("i_op4",    7, 0, 4, 0,  0, 0, 0);
      key(KOP,  4'd6); expectNext("i_op6",    7, 0, 4, 0,  0, 0, 0);
      key(KENT, 4'd0); expectNext("i_ent0",   7, 0, 4, 0,  0, 0, 0);
      key(KDIG, 4'd9); expectNext("i_d9",     7, 9, 4, 0,  9, 0, 0);
      key(KOP,  4'd0); expectNext("i_oplate", 7, 9, 4, 0,  9, 0, 0);

      // Timeout: ERROR exactly 16 cycles after alu_en
      key(KENT, 4'd0); expectNext("t_exec",   7, 9, 4, 1,  9, 0, 1);
      for (int k = 1; k <= 15; k++) begin
         idle();       expectNext("t_wait",   7, 9, 4, 0,  9, 0, 1);
      end
      idle();          expectNext("t_err",    7, 9, 4, 0,  0, 1, 0);
      key(KCLR, 4'd0); expectNext("clr3",     0, 0, 0, 0,  0, 0, 0);

      // alu_done on the final count beats the timeout; keys ignored in WAIT
      key(KDIG, 4'd3); expectNext("l_d3",     3, 0, 0, 0,  3, 0, 0);
      key(KOP,  4'd2); expectNext("l_op2",    3, 0, 2, 0,  0, 0, 0);
      key(KDIG, 4'd8); expectNext("l_d8",     3, 8, 2, 0,  8, 0, 0);
      key(KENT, 4'd0); expectNext("l_exec",   3, 8, 2, 1,  8, 0, 1);
      for (int k = 1; k <= 15; k++) begin
         if (k == 2) key(KDIG, 4'd5);
         else        idle();
         expectNext("l_wait", 3, 8, 2, 0, 8, 0, 1);
      end
      aluResp(1'b0, 9'd24); expectNext("l_res", 3, 8, 2, 0, 24, 0, 0);

      // Digit from RESULT restarts the first operand
      key(KDIG, 4'd7); expectNext("r_d7",     7, 8, 2, 0,  7, 0, 0);
      key(KOP,  4'd0); expectNext("r_op0",    7, 0, 0, 0,  0, 0, 0);
      key(KDIG, 4'd1); expectNext("r_d1",     7, 1, 0, 0,  1, 0, 0);
      key(KENT, 4'd0); expectNext("r_exec",   7, 1, 0, 1,  1, 0, 1);
      idle();          expectNext("r_wait",   7, 1, 0, 0,  1, 0, 1);
      // Clear and alu_done together: clear wins
      applyStimulus(1'b1, KCLR, 4'd0, 1'b1, 1'b0, 9'd8);
      expectNext("clr_done", 0, 0, 0, 0, 0, 0, 0);

      // ALU overflow flag sends the controller to ERROR
      key(KDIG, 4'd2); expectNext("v_d2",     2, 0, 0, 0,  2, 0, 0);
      key(KOP,  4'd2); expectNext("v_op2",    2, 0, 2, 0,  0, 0, 0);
      key(KDIG, 4'd3); expectNext("v_d3",     2, 3, 2, 0,  3, 0, 0);
      key(KENT, 4'd0); expectNext("v_exec",   2, 3, 2, 1,  3, 0, 1);
      idle();          expectNext("v_wait",   2, 3, 2, 0,  3, 0, 1);
      aluResp(1'b1, 9'd6); expectNext("v_err", 2, 3, 2, 0, 0, 1, 0);
      key(KCLR, 4'd0); expectNext("clr4",     0, 0, 0, 0,  0, 0, 0);

      // Reset mid-WAIT acts without a clock edge; a late alu_done is ignored
      key(KDIG, 4'd4); expectNext("w_d4",     4, 0, 0, 0,  4, 0, 0);
      key(KOP,  4'd0); expectNext("w_op0",    4, 0, 0, 0,  0, 0, 0);
      key(KDIG, 4'd5); expectNext("w_d5",     4, 5, 0, 0,  5, 0, 0);
      key(KENT, 4'd0); expectNext("w_exec",   4, 5, 0, 1,  5, 0, 1);
      idle();          expectNext("w_wait",   4, 5, 0, 0,  5, 0, 1);
      @(negedge clk);
      @(posedge clk);
      #2;
      nrst = 1'b0;
      pushExp("rst_async", cycleCnt, 0, 0, 0, 0, 0, 0, 0);
      aluResp(1'b0, 9'd99);
      nrst = 1'b1;
      expectNext("late_done", 0, 0, 0, 0, 0, 0, 0);
      idle();          expectNext("post_rst", 0, 0, 0, 0,  0, 0, 0);

      // Let the monitor drain; anything left over was never checked
      idle();
      for (int k = 0; k < 20 && expQ.size() > 0; k++) @(negedge clk);
      if (expQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Sequencing controller for the calculator datapath. It consumes debounced keypad strobes, builds two decimal operands, selects the ALU opcode, issues a single-cycle ALU enable, waits for the ALU's ready handshake with a timeout, and latches the result for the seven-segment and LED drivers. It sits between the push-button decoder and the ALU inside the calculator block.

## Interface
Parameters:
- `ALU_TIMEOUT`, default 15: cycles to wait for `alu_done` after `alu_en` before declaring an error.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `nrst`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; key fields are valid in the same cycle.
- `key_type`  in  2  0 = digit, 1 = op, 2 = enter, 3 = clear.
- `key_val`  in  4  digit 0–9, or opcode in bits [2:0].
- `alu_done`  in  1  ALU result ready; level, sampled only in WAIT.
- `alu_ovf`  in  1  ALU overflow flag; qualified by `alu_done`.
- `alu_result`  in  9  ALU result; qualified by `alu_done`.
- `op1`, `op2`  out  8  unsigned operand registers.
- `opcode`  out  3  latched opcode; valid values are 0–5.
- `alu_en`  out  1  one-cycle start pulse.
- `disp_val`  out  9  value to display.
- `err`  out  1  high in ERROR (drives red).
- `busy`  out  1  high in EXEC or WAIT (drives blue).

## Operation
States are OP1, OP2, EXEC, WAIT, RESULT and ERROR. Reset state is OP1.

Key rules:
- Clear, accepted in any state: zero all registers, go to OP1. Clear has priority over every other event in the same cycle, including `alu_done`.
- Digit key with `key_val` greater than 9: ignored.
- Op key with opcode greater than 5: ignored.
- Any key other than clear, received in EXEC or WAIT: ignored.

Per-state behaviour:
- OP1
  - Digit: `op1 = op1*10 + d`.
  - Op: latch `opcode`, clear `op2` and the `op2_seen` flag, go to OP2.
  - Enter: ignored.
- OP2
  - Digit: `op2 = op2*10 + d`, set `op2_seen`.
  - Op: replace `opcode` only if `op2_seen` = 0; otherwise ignored.
  - Enter: with `op2_seen` = 1, go to EXEC; otherwise ignored.
- EXEC: assert `alu_en` for one cycle, go to WAIT. Load the timeout counter with `ALU_TIMEOUT`.
- WAIT
  - `alu_done` = 1: if `alu_ovf` = 0, latch `alu_result` into the result register and go to RESULT; if `alu_ovf` = 1, go to ERROR.
  - Otherwise decrement the counter. When the counter reaches 0 with no `alu_done`, go to ERROR.
- RESULT
  - Digit: `op1 = d`, go to OP1.
  - Op: if `result[8]` = 0, set `op1 = result[7:0]`, latch `opcode`, go to OP2. If `result[8]` = 1, go to ERROR.
  - Enter: ignored.
- ERROR: only clear exits.

Arithmetic:
- Accumulate with a 12-bit intermediate.
- A result greater than 255 goes to ERROR and leaves the operand unchanged.

`disp_val` by state:
- OP1: `{1'b0, op1}`.
- OP2: `{1'b0, op2}`.
- EXEC and WAIT: `{1'b0, op2}`.
- RESULT: the result register.
- ERROR: 0.

## Timing
- All outputs are registered. A key strobe in cycle N is visible on the outputs in cycle N+1.
- Reset values:
  - state = OP1.
  - `op1`, `op2`, `opcode`, result and `disp_val` = 0.
  - `alu_en`, `err`, `busy` = 0.
- Reset acts immediately and asynchronously. This includes mid-WAIT; a late `alu_done` after reset is ignored.
- Enter in cycle N: EXEC in N+1, `alu_en` high in N+1 only, WAIT from N+2.
- `alu_done` in WAIT at cycle M: RESULT and the new `disp_val` in M+1.
- Timeout: with no `alu_done`, ERROR is entered exactly `ALU_TIMEOUT` + 1 cycles after `alu_en`.
- `alu_done` arriving in the same cycle as the last count wins over the timeout.
- `alu_en` never re-asserts until a new EXEC.

## Structure
- `calc_pkg` holds:
  - `state_t` enum;
  - `key_type_t` enum (`KEY_DIG`, `KEY_OP`, `KEY_ENT`, `KEY_CLR`);
  - `opcode_t` enum (`ADD`, `SUB`, `MUL`, `AND`, `OR`, `XOR` = 0–5);
  - `OPCODE_MAX` = 5 and `OPERAND_MAX` = 255.
- Sub-module `calc_digit_acc`: combinational `acc*10 + d`, producing an 8-bit sum and an `ovf` flag. It is instantiated once, with its input muxed between `op1` and `op2`.
- The FSM, timeout counter and registers live in `calc_ctrl`.

## Test plan
- Reset, then keys 1, 2, op 0, 3, enter; ALU returns `alu_done` with 15 two cycles after `alu_en` → `op1` = 12, `op2` = 3, `opcode` = 0, exactly one `alu_en` pulse, RESULT with `disp_val` = 15, `busy` low.
- Digits 2, 5, 6 in OP1 → ERROR, `err` = 1, `op1` stays 25; clear → OP1 with all outputs 0 on the next cycle.
- Enter, ALU never responds, `ALU_TIMEOUT` = 15 → ERROR exactly 16 cycles after `alu_en`. A second run with `alu_done` on the last count → RESULT.
- From RESULT = 15:
  - op 2 → `op1` = 15, state OP2.
  - A run with `result` = 9'h1FF and op → ERROR.
  - Digit 7 from RESULT → `op1` = 7, state OP1.
- In OP2:
  - Op 1 then op 4 before any digit → `opcode` = 4.
  - Op 6 → ignored.
  - Enter before any digit → ignored.
  - Clear and `alu_done` in the same WAIT cycle → OP1.
- Reset asserted mid-WAIT → immediate reset values; a later `alu_done` causes no state change.
